// File: rtl/fir_pcpi_engine_if.sv
// PCPI co-processor bus between the CPU core (master) and the FIR engine (slave).
// The core holds insn/operands stable with pcpi_valid until pcpi_ready pulses.
interface fir_pcpi_engine_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/fir_pcpi_engine.sv
// PCPI FIR engine: N coefficient banks of K taps against a K-deep shift register of N-bit samples.
// Loads ack one cycle after issue; CALC holds the core with pcpi_wait for K/LANES cycles, dropping pcpi_valid aborts.
module fir_pcpi_engine #(
  parameter int N                 = 4,
  parameter int K                 = 256,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int LANES             = 16,
  parameter int OSR               = 15,
  parameter int ACC_WIDTH         = 48,
  parameter int OUT_SHIFT         = 0
) (
  input  logic             clk,
  input  logic             resetn,
  fir_pcpi_engine_if.slave pcpi
);
  localparam int W      = WIDTH_COEFFICIENT;
  localparam int CHUNKS = K / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACK, BUSY, DONE} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        hold_q, hold_d;
  logic signed [W-1:0]         h_q [N][K];
  logic signed [W-1:0]         h_d [N][K];
  logic [N-1:0]                s_q [K];
  logic [N-1:0]                s_d [K];
  logic [N-1:0]                s_shift [K];

  logic [2:0]  funct3;
  logic        is_ours, is_calc, is_loadh, is_loads, is_clear, accept;
  logic [63:0] p;
  logic        unused_bits;

  assign funct3   = pcpi.pcpi_insn[14:12];
  assign is_ours  = (pcpi.pcpi_insn[6:0] == 7'h27) && (pcpi.pcpi_insn[31:25] == 7'd0);
  assign is_calc  = is_ours && (funct3 == 3'd2);
  assign is_loadh = is_ours && (funct3 == 3'd3);
  assign is_loads = is_ours && (funct3 == 3'd4);
  assign is_clear = is_ours && (funct3 == 3'd5);
  assign p        = {pcpi.pcpi_rs2, pcpi.pcpi_rs1};

  // hold_q blocks the first IDLE cycle so a still-asserted valid cannot re-issue
  assign accept = (state_q == IDLE) && !hold_q && pcpi.pcpi_valid &&
                  (is_calc || is_loadh || is_loads || is_clear);

  assign unused_bits = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7], p};

  always_comb begin
    s_shift = s_q;
    for (int i = 0; i < K - OSR; i++) s_shift[i] = s_q[i + OSR];
    for (int j = 0; j < OSR; j++) s_shift[K - OSR + j] = p[j*N +: N];
  end

  always_comb begin
    h_d = h_q;
    s_d = s_q;
    if (accept) begin
      if (is_loads || is_calc) s_d = s_shift;
      if (is_clear) s_d = '{default: '0};
      if (is_loadh) begin
        for (int b = 0; b < N; b++) begin
          if (pcpi.pcpi_rs2[2:0] == 3'(b)) begin
            for (int i = K - 1; i > 0; i--) h_d[b][i] = h_q[b][i-1];
            h_d[b][0] = pcpi.pcpi_rs1[W-1:0];
          end
        end
      end
    end
  end

  // Route the active chunk onto a single LANES-wide adder tree
  logic signed [W-1:0]         lane_h [N][LANES];
  logic [N-1:0]                lane_s [LANES];
  logic signed [ACC_WIDTH-1:0] chunk_sum;
  logic signed [ACC_WIDTH-1:0] term;

  always_comb begin
    lane_h = '{default: '0};
    lane_s = '{default: '0};
    for (int c = 0; c < CHUNKS; c++) begin
      if (cnt_q == CW'(c)) begin
        for (int l = 0; l < LANES; l++) begin
          lane_s[l] = s_q[c*LANES + l];
          for (int n = 0; n < N; n++) lane_h[n][l] = h_q[n][c*LANES + l];
        end
      end
    end
  end

  always_comb begin
    chunk_sum = '0;
    term      = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int n = 0; n < N; n++) begin
        term = $signed({{(ACC_WIDTH-W){lane_h[n][l][W-1]}}, lane_h[n][l]});
        if (lane_s[l][n]) chunk_sum = chunk_sum + term;
        else              chunk_sum = chunk_sum - term;
      end
    end
  end

  logic signed [ACC_WIDTH-1:0] acc_shr;
  logic [31:0]                 sat_res;

  assign acc_shr = acc_q >>> OUT_SHIFT;
  assign sat_res = (acc_shr > SAT_MAX) ? 32'h7FFF_FFFF :
                   (acc_shr < SAT_MIN) ? 32'h8000_0000 : acc_shr[31:0];

  logic        ready, wr, busy;
  logic [31:0] rd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    hold_d  = (state_q != IDLE);
    ready   = 1'b0;
    wr      = 1'b0;
    busy    = 1'b0;
    rd      = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = is_calc ? BUSY : ACK;
          if (is_calc) begin
            cnt_d = '0;
            acc_d = '0;
          end
        end
      end
      ACK: begin
        ready   = pcpi.pcpi_valid;
        state_d = IDLE;
      end
      BUSY: begin
        busy = 1'b1;
        if (!pcpi.pcpi_valid) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + chunk_sum;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(CHUNKS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        ready   = pcpi.pcpi_valid;
        wr      = pcpi.pcpi_valid;
        rd      = sat_res;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pcpi.pcpi_ready = ready;
  assign pcpi.pcpi_wr    = wr;
  assign pcpi.pcpi_wait  = busy;
  assign pcpi.pcpi_rd    = rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      hold_q  <= 1'b0;
      h_q     <= '{default: '0};
      s_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      hold_q  <= hold_d;
      h_q     <= h_d;
      s_q     <= s_d;
    end
  end
endmodule
